// File: rtl/mc_control_fsm.sv
// Main control FSM for the multicycle datapath: a Moore machine that sequences
// instruction fetch, decode and the per-opcode execute/memory/write-back phases.
module mc_control_fsm #(
    parameter int OPW = 6,
    parameter int STW = 4
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [OPW-1:0] Opcode,
    input  logic           Zero,
    output logic           IRWrite,
    output logic           PCWrite,
    output logic           MemWrite,
    output logic           RegWrite,
    output logic           IorD,
    output logic           MemtoReg,
    output logic           RegDst,
    output logic           ALUSrcA,
    output logic [1:0]     ALUSrcB,
    output logic [1:0]     ALUOp,
    output logic [1:0]     PCSrc,
    output logic [STW-1:0] State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);

    state_t state, next_state;

    logic ir_write, pc_write_u, branch, mem_write, reg_write;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value, independent of block ordering.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= FETCH;
        else     state <= next_state;
    end

    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:  next_state = DECODE;
            DECODE: begin
                if (Opcode == OP_LW || Opcode == OP_SW) next_state = MEMADR;
                else if (Opcode == OP_RTYPE)            next_state = EXECUTE;
                else if (Opcode == OP_BEQ)              next_state = BRANCH;
                else if (Opcode == OP_ADDI)             next_state = ADDIEXEC;
                else if (Opcode == OP_J)                next_state = JUMP;
                else                                    next_state = FETCH;
            end
            MEMADR:   next_state = (Opcode == OP_SW) ? MEMWRITE : MEMREAD;
            MEMREAD:  next_state = MEMWB;
            EXECUTE:  next_state = ALUWB;
            ADDIEXEC: next_state = ADDIWB;
            default:  next_state = FETCH;
        endcase
    end

    always_comb begin
        ir_write   = 1'b0;
        pc_write_u = 1'b0;
        branch     = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        IorD       = 1'b0;
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        PCSrc      = 2'b00;
        case (state)
            FETCH: begin
                ir_write   = 1'b1;
                pc_write_u = 1'b1;
                ALUSrcB    = 2'b01;
            end
            DECODE:   ALUSrcB = 2'b11;
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMREAD:  IorD = 1'b1;
            MEMWB: begin
                reg_write = 1'b1;
                MemtoReg  = 1'b1;
            end
            MEMWRITE: begin
                IorD      = 1'b1;
                mem_write = 1'b1;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            ALUWB: begin
                reg_write = 1'b1;
                RegDst    = 1'b1;
            end
            BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b01;
                PCSrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ADDIWB:   reg_write = 1'b1;
            JUMP: begin
                pc_write_u = 1'b1;
                PCSrc      = 2'b10;
            end
            default: ;
        endcase
    end

    // Enables are masked by the raw reset so nothing writes while RST is held.
    assign IRWrite  = ir_write & ~RST;
    assign PCWrite  = (pc_write_u | (branch & Zero)) & ~RST;
    assign MemWrite = mem_write & ~RST;
    assign RegWrite = reg_write & ~RST;
    assign State    = STW'(state);

endmodule
